// File: rtl/rom_ctrl_pkg.sv
// Shared types for the ROM controller arbiter: mubi4 values, sparse owner
// FSM encodings and the bus response entry layout.
package rom_ctrl_pkg;

  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  localparam int RomArbStateWidth = 10;

  // Sparse encodings, pairwise Hamming distance >= 5, so a single upset
  // cannot turn one valid state into another.
  typedef enum logic [RomArbStateWidth-1:0] {
    ChkOwn   = 10'b0110110010,
    Drain    = 10'b1011001101,
    BusOwn   = 10'b0001111100,
    ArbError = 10'b1100000111
  } arb_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_entry_t;

  // Bits needed to address n words (at least one bit).
  function automatic int vbits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_ctrl_arb_rsp_fifo.sv
// Bus response FIFO: Depth entries, head read straight from the storage
// registers, occupancy count and an overflow/underflow error flag.
module rom_ctrl_arb_rsp_fifo
  import rom_ctrl_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  rsp_entry_t                 wdata_i,
  input  logic                       pop_i,
  output logic                       rvalid_o,
  output rsp_entry_t                 rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  rsp_entry_t            mem [Depth];
  logic [PtrW-1:0]       wptr_reg, rptr_reg;
  logic [CntW-1:0]       count_reg;
  logic                  full, empty, wr_en, rd_en;

  assign full  = (count_reg == CntW'(Depth));
  assign empty = (count_reg == '0);
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign wr_en = push_i & (~full | pop_i) & ~flush_i;
  assign rd_en = pop_i & ~empty & ~flush_i;
  assign err_o = (push_i & full & ~pop_i) | (pop_i & empty);

  assign rvalid_o = ~empty;
  assign rdata_o  = mem[rptr_reg];
  assign count_o  = count_reg;

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr_reg] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en) wptr_reg <= (wptr_reg == PtrW'(Depth - 1)) ? '0 : wptr_reg + 1'b1;
      if (rd_en) rptr_reg <= (rptr_reg == PtrW'(Depth - 1)) ? '0 : rptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rom_ctrl_rom_arb.sv
// ROM port arbiter between the checker FSM and the bus fetch port. Ownership
// follows rom_select_bus_i with a drain phase; inconsistencies latch alert_o.
// Optional macro ROM_CTRL_ARB_ADDR_CHECK_EN: out-of-range bus reads answer
// with an error response instead of strobing the ROM.
module rom_ctrl_rom_arb
  import rom_ctrl_pkg::*;
#(
  parameter  int RomDepth = 16,
  parameter  int RspDepth = 2,
  localparam int AW       = vbits(RomDepth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  mubi4_t        rom_select_bus_i,
  input  logic          chk_req_i,
  input  logic [AW-1:0] chk_addr_i,
  output logic          chk_gnt_o,
  output logic          chk_rvalid_o,
  output logic [31:0]   chk_rdata_o,
  input  logic          bus_req_i,
  input  logic [AW-1:0] bus_addr_i,
  output logic          bus_gnt_o,
  output logic          bus_rvalid_o,
  output logic [31:0]   bus_rdata_o,
  output logic          bus_rerr_o,
  input  logic          bus_rready_i,
  output logic          rom_req_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [31:0]   rom_rdata_i,
  output logic          alert_o
);

  localparam int CntW = $clog2(RspDepth + 1);

  logic [RomArbStateWidth-1:0] state_reg;
  arb_state_e                  state_next;
  logic                        pend_reg, tag_bus_reg, err_reg;
  logic [AW-1:0]               addr_hold_reg;
  logic                        in_err, sel_true, sel_false;
  logic                        chk_inflight, bus_inflight, credit_ok, bus_oob;
  logic                        fifo_push, fifo_pop, fifo_err;
  logic [CntW-1:0]             fifo_count;
  rsp_entry_t                  fifo_wdata, fifo_head;

  assign in_err    = (state_reg == ArbError);
  assign sel_true  = (rom_select_bus_i == MuBi4True);
  assign sel_false = (rom_select_bus_i == MuBi4False);
  assign alert_o   = in_err;

  assign chk_inflight = pend_reg & ~tag_bus_reg;
  assign bus_inflight = pend_reg & tag_bus_reg;
  // A pop in this cycle frees its slot, keeping one read per cycle sustainable.
  assign credit_ok = (int'(bus_inflight) + int'(fifo_count) - int'(fifo_pop)) < RspDepth;

`ifdef ROM_CTRL_ARB_ADDR_CHECK_EN
  assign bus_oob = (int'(bus_addr_i) >= RomDepth);
`else
  assign bus_oob = 1'b0;
`endif

  // State register; reset returns ownership to the checker.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= ChkOwn;
    else       state_reg <= state_next;
  end

  // Owner FSM next state and grants.
  always_comb begin
    state_next = ArbError;
    chk_gnt_o  = 1'b0;
    bus_gnt_o  = 1'b0;
    case (state_reg)
      ChkOwn: begin
        chk_gnt_o = chk_req_i;
        if (sel_true)        state_next = Drain;
        else if (sel_false)  state_next = ChkOwn;
        else                 state_next = ArbError;
      end
      Drain: begin
        if (!sel_true)         state_next = ArbError;
        else if (!chk_inflight) state_next = BusOwn;
        else                    state_next = Drain;
      end
      BusOwn: begin
        bus_gnt_o = bus_req_i & credit_ok;
        if (chk_req_i || !sel_true) state_next = ArbError;
        else                        state_next = BusOwn;
      end
      default: state_next = ArbError;
    endcase
    if (fifo_err) state_next = ArbError;
  end

  assign rom_req_o  = chk_gnt_o | (bus_gnt_o & ~bus_oob);
  assign rom_addr_o = rom_req_o ? (chk_gnt_o ? chk_addr_i : bus_addr_i) : addr_hold_reg;

  // Track the read issued this cycle so its data can be routed next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_reg      <= 1'b0;
      tag_bus_reg   <= 1'b0;
      err_reg       <= 1'b0;
      addr_hold_reg <= '0;
    end else begin
      pend_reg    <= chk_gnt_o | bus_gnt_o;
      tag_bus_reg <= bus_gnt_o;
      err_reg     <= bus_gnt_o & bus_oob;
      if (rom_req_o) addr_hold_reg <= rom_addr_o;
    end
  end

  // Responses are dropped once in ArbError.
  assign chk_rvalid_o    = chk_inflight & ~in_err;
  assign chk_rdata_o     = chk_rvalid_o ? rom_rdata_i : '0;
  assign fifo_push       = bus_inflight & ~in_err;
  assign fifo_wdata.data = err_reg ? '0 : rom_rdata_i;
  assign fifo_wdata.err  = err_reg;
  assign fifo_pop        = bus_rvalid_o & bus_rready_i;

  rom_ctrl_arb_rsp_fifo #(
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (in_err),
    .push_i   (fifo_push),
    .wdata_i  (fifo_wdata),
    .pop_i    (fifo_pop),
    .rvalid_o (bus_rvalid_o),
    .rdata_o  (fifo_head),
    .count_o  (fifo_count),
    .err_o    (fifo_err)
  );

  assign bus_rdata_o = bus_rvalid_o ? fifo_head.data : '0;
  assign bus_rerr_o  = bus_rvalid_o & fifo_head.err;

endmodule

// File: tb/tb_rom_ctrl_rom_arb.sv
// Directed bench for rom_ctrl_rom_arb: checker reads, handover, bus
// back-pressure, select glitch, late checker request and (with
// ROM_CTRL_ARB_ADDR_CHECK_EN) an out-of-range bus read.
module tb_rom_ctrl_rom_arb;
  import rom_ctrl_pkg::*;

`ifdef ROM_CTRL_ARB_ADDR_CHECK_EN
  localparam int ROM_DEPTH = 12;
`else
  localparam int ROM_DEPTH = 16;
`endif
  localparam int AW = vbits(ROM_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    sel;
  logic          chk_req, bus_req, bus_rready;
  logic [AW-1:0] chk_addr, bus_addr;
  logic          chk_gnt, chk_rvalid, bus_gnt, bus_rvalid, bus_rerr, rom_req, alert;
  logic [31:0]   chk_rdata, bus_rdata;
  logic [31:0]   rom_rdata = 32'h0;
  logic [AW-1:0] rom_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rom_ctrl_rom_arb #(.RomDepth(ROM_DEPTH), .RspDepth(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rom_select_bus_i (sel),
    .chk_req_i        (chk_req),
    .chk_addr_i       (chk_addr),
    .chk_gnt_o        (chk_gnt),
    .chk_rvalid_o     (chk_rvalid),
    .chk_rdata_o      (chk_rdata),
    .bus_req_i        (bus_req),
    .bus_addr_i       (bus_addr),
    .bus_gnt_o        (bus_gnt),
    .bus_rvalid_o     (bus_rvalid),
    .bus_rdata_o      (bus_rdata),
    .bus_rerr_o       (bus_rerr),
    .bus_rready_i     (bus_rready),
    .rom_req_o        (rom_req),
    .rom_addr_o       (rom_addr),
    .rom_rdata_i      (rom_rdata),
    .alert_o          (alert)
  );

  // ROM model: word at address a reads 0xA0 + a, one cycle after the strobe.
  always @(posedge clk) begin
    if (rom_req) rom_rdata <= 32'hA0 + 32'(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    $display("check %-14s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = MuBi4False; chk_req = 1'b0; chk_addr = '0;
    bus_req = 1'b0; bus_addr = '0; bus_rready = 1'b0;
    tick();
    tick();
    // Reset values (reset still asserted).
    settle();
    check("rst_alert", alert, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_req", rom_req, 0);
    check("rst_chk_rvalid", chk_rvalid, 0);
    check("rst_bus_rvalid", bus_rvalid, 0);
    rst = 1'b0;
    tick();

    // Checker reads 0..3 back to back; bus request must not be granted.
    bus_req = 1'b1; bus_addr = 4'd9;
    for (int i = 0; i < 5; i++) begin
      chk_req  = (i < 4);
      chk_addr = AW'(i % 4);
      settle();
      if (i < 4) begin
        check("chk_gnt", chk_gnt, 1);
        check("chk_rom_addr", rom_addr, i);
      end
      if (i > 0) begin
        check("chk_rvalid", chk_rvalid, 1);
        check("chk_rdata", chk_rdata, 32'hA0 + i - 1);
      end
      check("chk_bus_gnt", bus_gnt, 0);
      tick();
    end
    settle();
    check("chk_rvalid_idle", chk_rvalid, 0);
    check("rom_addr_hold", rom_addr, 3);

    // Handover: read at 5 in flight when select flips to True.
    chk_req = 1'b1; chk_addr = 4'd5; bus_req = 1'b0;
    settle();
    check("ho_chk_gnt", chk_gnt, 1);
    tick();
    chk_req = 1'b0; sel = MuBi4True; bus_req = 1'b1; bus_addr = 4'd7;
    settle();
    check("ho_chk_rvalid", chk_rvalid, 1);
    check("ho_chk_rdata", chk_rdata, 32'hA5);
    check("ho_bus_gnt0", bus_gnt, 0);
    tick();
    settle();
    check("drain_bus_gnt", bus_gnt, 0);
    check("drain_bus_rv", bus_rvalid, 0);
    tick();

    // BusOwn: three back-to-back reads at 7,8,9 with rready high.
    bus_rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus_req  = (k < 3);
      bus_addr = AW'(7 + (k % 3));
      settle();
      if (k < 3) check("tp_bus_gnt", bus_gnt, 1);
      if (k >= 2 && k < 5) begin
        check("tp_rvalid", bus_rvalid, 1);
        check("tp_rdata", bus_rdata, 32'hA0 + 7 + k - 2);
      end
      if (k == 5) check("tp_rvalid_end", bus_rvalid, 0);
      tick();
    end

    // Back-pressure: rready low, three requests at 1,2,3.
    bus_rready = 1'b0; bus_req = 1'b1; bus_addr = 4'd1;
    settle(); check("bp_gnt0", bus_gnt, 1); tick();
    bus_addr = 4'd2;
    settle(); check("bp_gnt1", bus_gnt, 1); tick();
    bus_addr = 4'd3;
    settle(); check("bp_stall0", bus_gnt, 0); check("bp_rom_req", rom_req, 0);
    check("bp_head", bus_rdata, 32'hA1); tick();
    settle(); check("bp_stall1", bus_gnt, 0); tick();
    bus_rready = 1'b1;
    settle(); check("bp_release", bus_gnt, 1); check("bp_rdata1", bus_rdata, 32'hA1);
    check("bp_rom_addr", rom_addr, 3); tick();
    bus_req = 1'b0;
    settle(); check("bp_rdata2", bus_rdata, 32'hA2); tick();
    settle(); check("bp_rdata3", bus_rdata, 32'hA3); check("bp_rerr", bus_rerr, 0); tick();
    settle(); check("bp_empty", bus_rvalid, 0);
    check("bp_alert", alert, 0);
    tick();

    // Select glitch in BusOwn.
    sel = 4'b0101; bus_req = 1'b1; bus_addr = 4'd4;
    tick();
    settle();
    check("gl_alert", alert, 1);
    check("gl_rom_req", rom_req, 0);
    check("gl_bus_gnt", bus_gnt, 0);
    tick();
    sel = MuBi4True;
    settle();
    check("gl_alert_stk", alert, 1);
    check("gl_rvalid", bus_rvalid, 0);
    bus_req = 1'b0;

    // Reset mid-operation, then late checker request in BusOwn.
    do_reset();
    settle();
    check("lc_alert_rst", alert, 0);
    tick();
    tick();
    bus_req = 1'b1; bus_addr = 4'd2;
    settle();
    check("lc_bus_gnt", bus_gnt, 1);
    tick();
    bus_req = 1'b0; chk_req = 1'b1; chk_addr = 4'd1;
    settle();
    check("lc_chk_gnt", chk_gnt, 0);
    check("lc_alert0", alert, 0);
    tick();
    settle();
    check("lc_alert1", alert, 1);
    check("lc_rom_req", rom_req, 0);
    chk_req = 1'b0;

`ifdef ROM_CTRL_ARB_ADDR_CHECK_EN
    // Out-of-range bus read returns an error response, no ROM strobe.
    do_reset();
    tick();
    tick();
    bus_rready = 1'b1; bus_req = 1'b1; bus_addr = 4'd13;
    settle();
    check("oob_gnt", bus_gnt, 1);
    check("oob_rom_req", rom_req, 0);
    tick();
    bus_req = 1'b0;
    settle();
    check("oob_rv_early", bus_rvalid, 0);
    tick();
    settle();
    check("oob_rvalid", bus_rvalid, 1);
    check("oob_rerr", bus_rerr, 1);
    check("oob_rdata", bus_rdata, 0);
    tick();
    bus_req = 1'b1; bus_addr = 4'd11;
    settle();
    check("inr_rom_req", rom_req, 1);
    tick();
    bus_req = 1'b0;
    tick();
    settle();
    check("inr_rerr", bus_rerr, 0);
    check("inr_rdata", bus_rdata, 32'hAB);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
